// File: rtl/fat32_pkg.sv
// Shared FAT32 directory-entry layout, marker bytes and scanner states.
package fat32_pkg;

    localparam logic [4:0] OFF_NAME      = 5'd0;
    localparam logic [4:0] OFF_EXT       = 5'd8;
    localparam logic [4:0] OFF_NAME_LAST = 5'd10;
    localparam logic [4:0] OFF_ATTR      = 5'd11;
    localparam logic [4:0] OFF_CLUS_HI   = 5'd20;
    localparam logic [4:0] OFF_CLUS_LO   = 5'd26;
    localparam logic [4:0] OFF_SIZE      = 5'd28;
    localparam logic [4:0] OFF_LAST      = 5'd31;

    localparam logic [7:0] MARK_END     = 8'h00;
    localparam logic [7:0] MARK_DELETED = 8'hE5;
    localparam logic [7:0] ATTR_LFN     = 8'h0F;
    localparam logic [7:0] ATTR_VOLUME  = 8'h08;
    localparam logic [7:0] ATTR_DIR     = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_REPORT
    } scan_state_e;

    // Expected 8.3 character for an entry offset (0-7 name, 8-10 extension).
    function automatic logic [7:0] nameChar(input logic [63:0] fname,
                                            input logic [23:0] ext,
                                            input logic [4:0]  off);
        logic [7:0] c;
        c = 8'h00;
        if (off < OFF_EXT)
            c = fname[8*(7 - int'(off)) +: 8];
        else if (off <= OFF_NAME_LAST)
            c = ext[8*(10 - int'(off)) +: 8];
        return c;
    endfunction

endpackage

// File: rtl/fat32_name_cmp.sv
// Byte-serial 11-character 8.3 name comparator; name_eq_o is meaningful on the offset-10 byte.
module fat32_name_cmp
    import fat32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic        entry_start_i,
    input  logic [4:0]  offset_i,
    input  logic [7:0]  byte_i,
    input  logic [63:0] filename_i,
    input  logic [23:0] extension_i,
    output logic        name_eq_o
);

    logic eqSoFar_q;
    logic charEq;

    assign charEq    = (byte_i == nameChar(filename_i, extension_i, offset_i));
    assign name_eq_o = charEq && (entry_start_i || eqSoFar_q);

    // Running equality, restarted by the first byte of every entry.
    always_ff @(negedge clk) begin
        if (!rst_n)
            eqSoFar_q <= 1'b0;
        else if (byte_valid_i && (offset_i <= OFF_NAME_LAST))
            eqSoFar_q <= name_eq_o;
    end

endmodule

// File: rtl/fat32_dir_scanner.sv
// FAT32 directory-sector scanner: finds a requested 8.3 name among the 16 entries of a sector.
// Optional FAT32_DIR_MATCH_SUBDIR_EN lets directory entries match and adds the is_dir output.
module fat32_dir_scanner
    import fat32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] filename,
    input  logic [23:0] extension,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        block_done,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        end_of_dir,
    output logic [3:0]  entry_index,
    output logic [31:0] first_cluster,
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
    output logic        is_dir,
`endif
    output logic [31:0] file_size
);

`ifdef FAT32_DIR_MATCH_SUBDIR_EN
    localparam logic [7:0] ATTR_REJECT_MASK = ATTR_VOLUME;
`else
    localparam logic [7:0] ATTR_REJECT_MASK = ATTR_VOLUME | ATTR_DIR;
`endif

    scan_state_e state_q;
    logic [8:0]  byteCnt_q;
    logic        cand_q;
    logic [31:0] clusSh_q;
    logic [23:0] sizeSh_q;
    logic        busy_q;
    logic        done_q;
    logic        match_q;
    logic        endOfDir_q;
    logic [3:0]  entryIdx_q;
    logic [31:0] firstClus_q;
    logic [31:0] fileSize_q;
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
    logic        dirSh_q;
    logic        isDir_q;
`endif

    logic [4:0] offset;
    logic       byteStrobe;
    logic       entryStart;
    logic       nameEq;

    assign offset     = byteCnt_q[4:0];
    assign byteStrobe = byte_valid && (state_q == ST_SCAN);
    assign entryStart = byteStrobe && (offset == OFF_NAME);

    fat32_name_cmp u_name_cmp (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_valid_i  (byteStrobe),
        .entry_start_i (entryStart),
        .offset_i      (offset),
        .byte_i        (byte_in),
        .filename_i    (filename),
        .extension_i   (extension),
        .name_eq_o     (nameEq)
    );

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byteCnt_q   <= '0;
            cand_q      <= 1'b0;
            clusSh_q    <= '0;
            sizeSh_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            endOfDir_q  <= 1'b0;
            entryIdx_q  <= '0;
            firstClus_q <= '0;
            fileSize_q  <= '0;
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
            dirSh_q     <= 1'b0;
            isDir_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        byteCnt_q   <= '0;
                        cand_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        match_q     <= 1'b0;
                        endOfDir_q  <= 1'b0;
                        entryIdx_q  <= '0;
                        firstClus_q <= '0;
                        fileSize_q  <= '0;
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
                        isDir_q     <= 1'b0;
`endif
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (byte_valid) begin
                        if (byteCnt_q != 9'd511)
                            byteCnt_q <= byteCnt_q + 9'd1;
                        case (offset)
                            OFF_NAME: begin
                                if (byte_in == MARK_END) begin
                                    endOfDir_q <= 1'b1;
                                    state_q    <= ST_DRAIN;
                                end else if (byte_in == MARK_DELETED) begin
                                    cand_q <= 1'b0;
                                end
                            end
                            OFF_NAME_LAST: if (!nameEq) cand_q <= 1'b0;
                            OFF_ATTR: begin
                                if ((byte_in == ATTR_LFN) || ((byte_in & ATTR_REJECT_MASK) != 8'h00))
                                    cand_q <= 1'b0;
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
                                dirSh_q <= byte_in[4];
`endif
                            end
                            OFF_CLUS_HI:          clusSh_q[23:16] <= byte_in;
                            OFF_CLUS_HI + 5'd1:   clusSh_q[31:24] <= byte_in;
                            OFF_CLUS_LO:          clusSh_q[7:0]   <= byte_in;
                            OFF_CLUS_LO + 5'd1:   clusSh_q[15:8]  <= byte_in;
                            OFF_SIZE:             sizeSh_q[7:0]   <= byte_in;
                            OFF_SIZE + 5'd1:      sizeSh_q[15:8]  <= byte_in;
                            OFF_SIZE + 5'd2:      sizeSh_q[23:16] <= byte_in;
                            OFF_LAST: begin
                                if (cand_q) begin
                                    match_q     <= 1'b1;
                                    entryIdx_q  <= byteCnt_q[8:5];
                                    firstClus_q <= clusSh_q;
                                    fileSize_q  <= {byte_in, sizeSh_q};
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
                                    isDir_q     <= dirSh_q;
`endif
                                    state_q     <= ST_DRAIN;
                                end else begin
                                    cand_q <= 1'b1;
                                    // Last entry of the sector examined: nothing left to scan.
                                    if (byteCnt_q == 9'd511)
                                        state_q <= ST_DRAIN;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (block_done) begin
                        state_q <= ST_REPORT;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (block_done) begin
                        state_q <= ST_REPORT;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_REPORT: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign match         = match_q;
    assign end_of_dir    = endOfDir_q;
    assign entry_index   = entryIdx_q;
    assign first_cluster = firstClus_q;
    assign file_size     = fileSize_q;
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
    assign is_dir        = isDir_q;
`endif

endmodule

// File: tb/tb_fat32_dir_scanner.sv
// Self-checking bench for fat32_dir_scanner: directed sectors checked against an entry-level model.
module tb_fat32_dir_scanner;

    typedef struct packed {
        logic        match;
        logic        eod;
        logic [3:0]  idx;
        logic [31:0] clus;
        logic [31:0] size;
        logic        dir;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] filename;
    logic [23:0] extension;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        block_done;
    logic        busy;
    logic        done;
    logic        match;
    logic        end_of_dir;
    logic [3:0]  entry_index;
    logic [31:0] first_cluster;
    logic [31:0] file_size;
    logic        is_dir;

    logic [7:0]  sector [0:511];
    logic [87:0] targetName;

    int      compared   = 0;
    int      mismatched = 0;
    bit      monEn   = 1'b0;
    bit      expBusy = 1'b0;
    bit      expDone = 1'b0;
    bit      resHeld = 1'b0;
    result_t expRes  = '0;

    always #5 clk = ~clk;

    fat32_dir_scanner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .filename      (filename),
        .extension     (extension),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .block_done    (block_done),
        .busy          (busy),
        .done          (done),
        .match         (match),
        .end_of_dir    (end_of_dir),
        .entry_index   (entry_index),
        .first_cluster (first_cluster),
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
        .is_dir        (is_dir),
`endif
        .file_size     (file_size)
    );

`ifndef FAT32_DIR_MATCH_SUBDIR_EN
    assign is_dir = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: walk whole entries received, first eligible match wins, 0x00 ends the directory.
    function automatic result_t modelScan(input int nBytes);
        result_t    r;
        int         n;
        int         b;
        bit         ok;
        logic [7:0] attr;
        r = '0;
        n = (nBytes > 512) ? 512 : nBytes;
        for (int e = 0; e < 16; e++) begin
            b = e * 32;
            if (b >= n) break;
            if (sector[b] == 8'h00) begin
                r.eod = 1'b1;
                break;
            end
            if (b + 32 > n) break;
            if (sector[b] == 8'hE5) continue;
            ok = 1'b1;
            for (int k = 0; k < 11; k++)
                if (sector[b + k] != targetName[87 - 8*k -: 8]) ok = 1'b0;
            attr = sector[b + 11];
            if (attr == 8'h0F || attr[3]) ok = 1'b0;
`ifndef FAT32_DIR_MATCH_SUBDIR_EN
            if (attr[4]) ok = 1'b0;
`endif
            if (ok) begin
                r.match = 1'b1;
                r.idx   = 4'(e);
                r.clus  = {sector[b+21], sector[b+20], sector[b+27], sector[b+26]};
                r.size  = {sector[b+31], sector[b+30], sector[b+29], sector[b+28]};
                r.dir   = attr[4];
                break;
            end
        end
        return r;
    endfunction

    // Single compare process: handshake outputs every cycle, held results whenever valid.
    always @(posedge clk) begin
        #1;
        if (monEn) begin
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(expDone));
            if (resHeld) begin
                checkOutput("match", 32'(match), 32'(expRes.match));
                checkOutput("end_of_dir", 32'(end_of_dir), 32'(expRes.eod));
                checkOutput("entry_index", 32'(entry_index), 32'(expRes.idx));
                checkOutput("first_cluster", first_cluster, expRes.clus);
                checkOutput("file_size", file_size, expRes.size);
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
                checkOutput("is_dir", 32'(is_dir), 32'(expRes.dir));
`endif
            end
        end
    end

    task automatic setEntry(input int e, input logic [87:0] nm, input logic [7:0] attr,
                            input logic [31:0] clus, input logic [31:0] size);
        int b;
        b = e * 32;
        for (int k = 0; k < 32; k++) sector[b + k] = 8'h5A;
        for (int k = 0; k < 11; k++) sector[b + k] = nm[87 - 8*k -: 8];
        sector[b + 11] = attr;
        sector[b + 20] = clus[23:16];
        sector[b + 21] = clus[31:24];
        sector[b + 26] = clus[7:0];
        sector[b + 27] = clus[15:8];
        sector[b + 28] = size[7:0];
        sector[b + 29] = size[15:8];
        sector[b + 30] = size[23:16];
        sector[b + 31] = size[31:24];
    endtask

    task automatic fillSector();
        logic [87:0] nm;
        for (int e = 0; e < 16; e++) begin
            nm = "FILLR0  DAT";
            nm[47:40] = 8'h41 + 8'(e);
            setEntry(e, nm, 8'h20, 32'h100 + 32'(e), 32'(e) * 16);
        end
    endtask

    // Arm a scan, stream nBytes, then block_done (with the last byte or one cycle later).
    task automatic applyStimulus(input int nBytes, input bit bdWithLast, input int startPulseAt);
        result_t r;
        r = modelScan(nBytes);
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start   = 1'b0;
        expBusy = 1'b1;
        resHeld = 1'b0;
        monEn   = 1'b1;
        for (int i = 0; i < nBytes; i++) begin
            byte_in    = sector[i];
            byte_valid = 1'b1;
            start      = (i == startPulseAt);
            block_done = bdWithLast && (i == nBytes - 1);
            @(posedge clk);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (!bdWithLast) begin
            block_done = 1'b1;
            @(posedge clk);
        end
        block_done = 1'b0;
        expRes     = r;
        expDone    = 1'b1;
        expBusy    = 1'b0;
        resHeld    = 1'b1;
        @(posedge clk);
        expDone = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        block_done = 1'b0;
        filename   = "README  ";
        extension  = "TXT";
        targetName = {filename, extension};
        repeat (3) @(posedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_match", 32'(match), 32'd0);
        checkOutput("rst_eod", 32'(end_of_dir), 32'd0);
        checkOutput("rst_idx", 32'(entry_index), 32'd0);
        checkOutput("rst_clus", first_cluster, 32'd0);
        checkOutput("rst_size", file_size, 32'd0);
        checkOutput("rst_is_dir", 32'(is_dir), 32'd0);
        rst_n = 1'b1;

        // Target in entry 3; lowercase lookalike in entry 0 must not match.
        fillSector();
        setEntry(0, "readme  txt", 8'h20, 32'h0000_0777, 32'h1);
        setEntry(3, targetName, 8'h20, 32'h0001_0005, 32'h0000_1234);
        applyStimulus(512, 1'b0, -1);
        checkOutput("t1_match", 32'(match), 32'd1);
        checkOutput("t1_idx", 32'(entry_index), 32'd3);
        checkOutput("t1_clus", first_cluster, 32'h0001_0005);
        checkOutput("t1_size", file_size, 32'h0000_1234);

        // Deleted copy in entry 0, live target in entry 1; stray start mid-scan ignored.
        fillSector();
        setEntry(0, targetName, 8'h20, 32'h0000_1111, 32'h1);
        sector[0] = 8'hE5;
        setEntry(1, targetName, 8'h20, 32'hAABB_CCDD, 32'h0000_0007);
        applyStimulus(512, 1'b0, 50);
        checkOutput("t2_match", 32'(match), 32'd1);
        checkOutput("t2_idx", 32'(entry_index), 32'd1);
        checkOutput("t2_clus", first_cluster, 32'hAABB_CCDD);

        // End marker in entry 2 hides the target in entry 5.
        fillSector();
        setEntry(5, targetName, 8'h20, 32'h0000_0055, 32'h55);
        sector[64] = 8'h00;
        applyStimulus(512, 1'b0, -1);
        checkOutput("t3_match", 32'(match), 32'd0);
        checkOutput("t3_eod", 32'(end_of_dir), 32'd1);

        // Directory entry with the target name.
        fillSector();
        setEntry(4, targetName, 8'h10, 32'h0000_0042, 32'h0);
        applyStimulus(512, 1'b0, -1);
`ifdef FAT32_DIR_MATCH_SUBDIR_EN
        checkOutput("t4_match", 32'(match), 32'd1);
        checkOutput("t4_is_dir", 32'(is_dir), 32'd1);
`else
        checkOutput("t4_match", 32'(match), 32'd0);
`endif

        // Volume label and LFN with the target name, real entry follows.
        fillSector();
        setEntry(2, targetName, 8'h08, 32'h0000_0222, 32'h2);
        setEntry(6, targetName, 8'h0F, 32'h0000_0666, 32'h6);
        setEntry(7, targetName, 8'h20, 32'h0003_0007, 32'h0000_5678);
        applyStimulus(512, 1'b0, -1);
        checkOutput("t5_idx", 32'(entry_index), 32'd7);
        checkOutput("t5_size", file_size, 32'h0000_5678);

        // Reset at byte 100, stale block_done in IDLE, then a fresh sector.
        fillSector();
        setEntry(9, targetName, 8'h20, 32'h0002_0009, 32'h99);
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start   = 1'b0;
        expBusy = 1'b1;
        resHeld = 1'b0;
        monEn   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            byte_in    = sector[i];
            byte_valid = 1'b1;
            @(posedge clk);
        end
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        monEn      = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_clus", first_cluster, 32'd0);
        expBusy    = 1'b0;
        expDone    = 1'b0;
        expRes     = '0;
        resHeld    = 1'b1;
        monEn      = 1'b1;
        block_done = 1'b1;
        @(posedge clk);
        block_done = 1'b0;
        repeat (3) @(posedge clk);
        applyStimulus(512, 1'b0, -1);
        checkOutput("t6_idx", 32'(entry_index), 32'd9);
        checkOutput("t6_clus", first_cluster, 32'h0002_0009);

        // Short sector: target in entry 9 is cut off at byte 300.
        applyStimulus(300, 1'b1, -1);
        checkOutput("t7_match", 32'(match), 32'd0);
        checkOutput("t7_eod", 32'(end_of_dir), 32'd0);

        // Target in the last entry, extra bytes past 511.
        fillSector();
        setEntry(15, targetName, 8'h20, 32'h000F_000F, 32'hDEAD_BEEF);
        applyStimulus(515, 1'b1, -1);
        checkOutput("t8_idx", 32'(entry_index), 32'd15);
        checkOutput("t8_size", file_size, 32'hDEAD_BEEF);

        // No match anywhere in a full sector.
        fillSector();
        applyStimulus(520, 1'b0, -1);
        checkOutput("t9_match", 32'(match), 32'd0);

        monEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fat32_dir_scanner.md
# fat32_dir_scanner

Byte-serial FAT32 directory-sector scanner sitting directly downstream of the SD card controller's read byte stream, alongside the FAT32 controller. For each 512-byte directory sector read, it compares every 32-byte entry against a requested 8.3 name and reports whether a match was found, with the matching entry's first cluster and file size. It also flags the end-of-directory marker so the FAT32 controller can stop walking the cluster chain.

## Interface
Parameters:
- none

Ports (all flops on falling edge of `clk`, same edge the SD byte stream is produced/consumed on):
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; arms a scan of the next sector
- `filename`  in  64  8-char name, space padded; char k = `filename[63-8k -: 8]`
- `extension`  in  24  3-char extension; char k = `extension[23-8k -: 8]`
- `byte_in`  in  8  sector byte from SD controller (`incoming_byte`)
- `byte_valid`  in  1  one-cycle strobe, `byte_in` valid (`finished_byte`)
- `block_done`  in  1  one-cycle strobe, sector complete (`finished_block`)
- `busy`  out  1  scan armed or in progress
- `done`  out  1  one-cycle pulse, sector scan result valid
- `match`  out  1  a matching entry was found in this sector
- `end_of_dir`  out  1  an entry with first byte 0x00 was seen
- `entry_index`  out  4  index (0-15) of the matching entry
- `first_cluster`  out  32  {bytes 21,20,27,26} of matching entry
- `file_size`  out  32  bytes 31..28 of matching entry, little-endian

## Operation
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE: `start` → clear byte counter, `match`, `end_of_dir`, `entry_index`, `first_cluster`, `file_size`; → SCAN. `start` while not IDLE is ignored.
- SCAN: each `byte_valid` advances a 9-bit byte counter; entry = count[8:5], offset = count[4:0].
  - Offset 0: 0x00 → set `end_of_dir`, go to DRAIN. 0xE5 → entry is deleted; mark candidate invalid.
  - Offsets 0-10: compare with name/ext chars; any mismatch clears the per-entry candidate flag. Comparison is exact and case-sensitive.
  - Offset 11 (attr): 0x0F (LFN), bit3 (volume label), or bit4 (directory) → candidate invalid.
  - Offsets 20, 21, 26, 27, 28-31: shift into shadow cluster/size registers.
  - Offset 31: if candidate is still valid, copy shadows to `first_cluster`/`file_size`, set `match`, latch `entry_index`, and go to DRAIN. Otherwise re-arm the candidate for the next entry.
- DRAIN: consume remaining `byte_valid` strobes without effect.
- `block_done` in SCAN or DRAIN → REPORT. A partial entry is never matched.
- REPORT: assert `done` for one cycle; → IDLE. Outputs hold until the next `start`.
- Bytes after count 511 are ignored (counter saturates at 511). `block_done` with fewer than 512 bytes is still reported normally.
- First match wins; later entries in the same sector are never examined.
- `byte_valid` and `block_done` in the same cycle: the byte is processed first, then the state moves to REPORT.

## Timing
- Reset values: `busy`=0, `done`=0, `match`=0, `end_of_dir`=0, `entry_index`=0, `first_cluster`=0, `file_size`=0, state IDLE.
- `busy` rises the cycle after `start` and falls in the same cycle `done` pulses.
- Result outputs are updated the cycle after the offset-31 (or offset-0) byte strobe.
- `done` pulses exactly one cycle after `block_done` is sampled.
- Reset asserted mid-scan returns to IDLE next edge; the partial result is discarded and no `done` is issued.
- One byte per cycle is sustained; there is no backpressure.

## Configuration
- `FAT32_DIR_MATCH_SUBDIR_EN` defined: entries with attr bit4 (directory) are eligible matches; LFN and volume-label entries are still rejected. A new output `is_dir` (1 bit, reset 0) is latched with the match.
- Undefined: directory entries are never matched, and `is_dir` does not exist.

## Structure
- Shared package `fat32_pkg`:
  - entry field offsets (NAME=0, EXT=8, ATTR=11, CLUS_HI=20, CLUS_LO=26, SIZE=28)
  - marker constants (END=8'h00, DELETED=8'hE5, ATTR_LFN=8'h0F)
  - attr bit masks
  - state enum localparams
- Sub-module `fat32_name_cmp`: 11-char byte-serial comparator (inputs: offset, byte, name/ext, `entry_start`; output: `name_eq` at offset 10). All other logic is top-level.

## Test plan
- Sector with "README  TXT" in entry 3, cluster 0x0001_0005, size 0x0000_1234 → `done`, `match`=1, `entry_index`=3, `first_cluster`=32'h0001_0005, `file_size`=32'h0000_1234.
- Entry 0 = 0xE5 deleted copy of target, entry 1 = live target → `match`=1, `entry_index`=1.
- Entry 2 with byte0=0x00, target in entry 5 → `match`=0, `end_of_dir`=1, `done` after `block_done`.
- Target name with attr 0x10 → `match`=0 without macro; `match`=1, `is_dir`=1 with `FAT32_DIR_MATCH_SUBDIR_EN`.
- LFN entry (attr 0x0F) whose bytes 0-10 equal the target → not matched; the following real entry is matched.
- `rst_n` low at byte 100 then `start` on a fresh sector → no stale `done`; the correct result is reported for the new sector.
